inst_axi_rd_bridge: RTL and testbench

- Converts the fetch stage's SRAM-like instruction interface (req / addr_ok / data_ok) into an AXI4 read-address and read-data channel pair.
- Sits directly upstream of the IF stage, feeding its instruction SRAM port, and supports up to OUTSTANDING in-flight reads with strictly in-order return.
- Fixed AXI sideband fields are driven constant by the CPU top and are not ports of this block: arlen=0, arburst=INCR, arlock, arcache, arprot.

---
 rtl/inst_axi_rd_bridge.sv | 96 +++++++++
 tb/tb_inst_axi_rd_bridge.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/inst_axi_rd_bridge.sv
// inst_axi_rd_bridge: SRAM-like instruction fetch port (req/addr_ok/data_ok)
// to AXI4 AR/R channels. Single-beat reads, one shared ID, up to OUTSTANDING
// reads in flight, returned strictly in order.
// Optional macro INST_BRIDGE_RRESP_CHK_EN adds inst_bus_err and zeroes
// inst_rdata on error beats.
module inst_axi_rd_bridge #(
    parameter int unsigned OUTSTANDING = 2,
    parameter logic [3:0]  ARID_VAL    = 4'd0
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        inst_req,
    input  logic        inst_wr,
    input  logic [1:0]  inst_size,
    input  logic [31:0] inst_addr,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    output logic [31:0] inst_rdata,
`ifdef INST_BRIDGE_RRESP_CHK_EN
    output logic        inst_bus_err,
`endif
    output logic [3:0]  arid,
    output logic [31:0] araddr,
    output logic [2:0]  arsize,
    output logic        arvalid,
    input  logic        arready,
    input  logic [3:0]  rid,
    input  logic [31:0] rdata,
    input  logic [1:0]  rresp,
    input  logic        rlast,
    input  logic        rvalid,
    output logic        rready
);

    localparam logic [2:0] MAX_CNT = 3'(OUTSTANDING);

    logic [2:0] cnt;
    logic [2:0] cnt_eff;
    logic       ret;
    logic       accept;

    // A read retires on its only (last) beat; a slot freed this cycle can be
    // handed to a new request in the same cycle.
    assign rready       = (cnt != 3'd0);
    assign ret          = rvalid && rready && rlast;
    assign cnt_eff      = cnt - {2'b00, ret};
    assign accept       = resetn && inst_req && !inst_wr &&
                          (!arvalid || arready) && (cnt_eff < MAX_CNT);
    assign inst_addr_ok = accept;
    assign inst_data_ok = ret;
    assign arid         = ARID_VAL;

`ifdef INST_BRIDGE_RRESP_CHK_EN
    logic err;
    assign err          = ret && rresp[1];
    assign inst_bus_err = err;
    assign inst_rdata   = err ? 32'h0 : rdata;

    logic unused_in;
    assign unused_in    = ^{rid, rresp[0]};
`else
    assign inst_rdata   = rdata;

    logic unused_in;
    assign unused_in    = ^{rid, rresp};
`endif

    // AR register: load on accept, hold until arready, back-to-back reload
    always_ff @(posedge clk) begin
        if (!resetn) begin
            arvalid <= 1'b0;
            araddr  <= 32'h0;
            arsize  <= 3'd0;
        end else if (accept) begin
            arvalid <= 1'b1;
            araddr  <= inst_addr;
            arsize  <= {1'b0, inst_size};
        end else if (arready) begin
            arvalid <= 1'b0;
        end
    end

    // In-flight counter: accepted but not yet returned
    always_ff @(posedge clk) begin
        if (!resetn) begin
            cnt <= 3'd0;
        end else begin
            case ({accept, ret})
                2'b10:   cnt <= cnt + 3'd1;
                2'b01:   cnt <= cnt - 3'd1;
                default: cnt <= cnt;
            endcase
        end
    end

endmodule

// File: tb/tb_inst_axi_rd_bridge.sv
// Randomized bench for inst_axi_rd_bridge with a queue-based reference model
// and an in-bench single-beat AXI slave; directed scenarios run first.
module tb_inst_axi_rd_bridge;

    localparam int OUT = 2;

    logic        clk = 1'b0;
    logic        resetn, inst_req, inst_wr;
    logic [1:0]  inst_size;
    logic [31:0] inst_addr;
    logic        inst_addr_ok, inst_data_ok;
    logic [31:0] inst_rdata;
`ifdef INST_BRIDGE_RRESP_CHK_EN
    logic        inst_bus_err;
`endif
    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [2:0]  arsize;
    logic        arvalid, arready;
    logic [3:0]  rid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast, rvalid, rready;

    inst_axi_rd_bridge #(.OUTSTANDING(OUT), .ARID_VAL(4'd0)) dut (
        .clk(clk), .resetn(resetn),
        .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size),
        .inst_addr(inst_addr), .inst_addr_ok(inst_addr_ok),
        .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
`ifdef INST_BRIDGE_RRESP_CHK_EN
        .inst_bus_err(inst_bus_err),
`endif
        .arid(arid), .araddr(araddr), .arsize(arsize), .arvalid(arvalid),
        .arready(arready), .rid(rid), .rdata(rdata), .rresp(rresp),
        .rlast(rlast), .rvalid(rvalid), .rready(rready)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // reference model: addresses accepted but not returned (in order),
    // addresses the slave has seen on AR but not yet returned, AR register
    logic [31:0] exp_q[$];
    logic [31:0] slv_q[$];
    bit          ar_pend;
    logic [31:0] ar_addr;
    logic [2:0]  ar_size;

    bit          r_en, stray_en;
    logic [1:0]  r_resp;
    bit          ok_seen, dok_seen, rdy_seen;
    logic [31:0] rd_seen;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    // slave memory contents, a fixed function of the address
    function automatic logic [31:0] mem(input logic [31:0] a);
        if (a == 32'hbfc0_0000) return 32'h3c1d_0000;
        return {a[15:0], ~a[31:16]} ^ 32'h1357_9bdf;
    endfunction

    // one clock: drive R, check outputs against the model, advance the model
    task automatic step();
        int          infl;
        bit          ret, eok;
        logic [31:0] erd;
        infl = exp_q.size();
        if (resetn && r_en && slv_q.size() != 0) begin
            rvalid = 1'b1; rlast = 1'b1; rdata = mem(slv_q[0]); rresp = r_resp;
        end else if (resetn && stray_en && infl == 0) begin
            rvalid = 1'b1; rlast = 1'b1; rdata = $urandom; rresp = r_resp;
        end else begin
            rvalid = 1'b0; rlast = 1'b0; rdata = 32'h0; rresp = 2'b00;
        end
        rid = 4'($urandom);
        #2;
        ret = rvalid && (infl != 0) && rlast;
        eok = resetn && inst_req && !inst_wr && (!ar_pend || arready) &&
              ((infl - int'(ret)) < OUT);
        chk("addr_ok", 32'(inst_addr_ok), 32'(eok));
        chk("arvalid", 32'(arvalid), 32'(ar_pend));
        chk("araddr", araddr, ar_addr);
        chk("arsize", 32'(arsize), 32'(ar_size));
        chk("arid", 32'(arid), 32'h0);
        chk("rready", 32'(rready), 32'(infl != 0));
        chk("data_ok", 32'(inst_data_ok), 32'(ret));
        ok_seen = inst_addr_ok; dok_seen = inst_data_ok;
        rdy_seen = rready; rd_seen = inst_rdata;
`ifdef INST_BRIDGE_RRESP_CHK_EN
        chk("bus_err", 32'(inst_bus_err), 32'(ret && r_resp[1]));
`endif
        if (ret) begin
            erd = mem(exp_q[0]);
`ifdef INST_BRIDGE_RRESP_CHK_EN
            if (r_resp[1]) erd = 32'h0;
`endif
            chk("rdata", inst_rdata, erd);
        end
        if (!resetn) begin
            exp_q.delete(); slv_q.delete();
            ar_pend = 1'b0; ar_addr = 32'h0; ar_size = 3'd0;
        end else begin
            if (ar_pend && arready) slv_q.push_back(araddr);
            if (ret) begin
                void'(slv_q.pop_front());
                void'(exp_q.pop_front());
            end
            if (eok) begin
                exp_q.push_back(inst_addr);
                ar_addr = inst_addr; ar_size = {1'b0, inst_size}; ar_pend = 1'b1;
            end else if (arready) begin
                ar_pend = 1'b0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        bit any_ok;
        resetn = 1'b0; inst_req = 1'b0; inst_wr = 1'b0; inst_size = 2'd2;
        inst_addr = 32'h0; arready = 1'b0; r_en = 1'b0; stray_en = 1'b0;
        r_resp = 2'b00; ar_pend = 1'b0; ar_addr = 32'h0; ar_size = 3'd0;
        rvalid = 1'b0; rlast = 1'b0; rdata = 32'h0; rresp = 2'b00; rid = 4'h0;
        @(negedge clk);
        step(); step();
        chk("rst_arvalid", 32'(arvalid), 32'h0);
        chk("rst_araddr", araddr, 32'h0);
        chk("rst_arsize", 32'(arsize), 32'h0);
        chk("rst_rready", 32'(rready), 32'h0);

        // single fetch, zero-wait slave
        resetn = 1'b1; arready = 1'b1; r_en = 1'b1;
        inst_req = 1'b1; inst_addr = 32'hbfc0_0000; inst_size = 2'd2;
        step();
        chk("t1_addr_ok", 32'(ok_seen), 32'h1);
        inst_req = 1'b0;
        chk("t1_arvalid", 32'(arvalid), 32'h1);
        chk("t1_araddr", araddr, 32'hbfc0_0000);
        chk("t1_arsize", 32'(arsize), 32'h2);
        step();
        step();
        chk("t1_data_ok", 32'(dok_seen), 32'h1);
        chk("t1_rdata", rd_seen, 32'h3c1d_0000);
        chk("t1_idle", 32'(rready), 32'h0);

        // outstanding limit
        r_en = 1'b0; inst_req = 1'b1; inst_addr = 32'h0; step();
        chk("lim_ok0", 32'(ok_seen), 32'h1);
        inst_addr = 32'h4; step();
        chk("lim_ok1", 32'(ok_seen), 32'h1);
        inst_addr = 32'h8; step();
        chk("lim_full0", 32'(ok_seen), 32'h0);
        step();
        chk("lim_full1", 32'(ok_seen), 32'h0);
        r_en = 1'b1; step();
        chk("lim_reuse", 32'(ok_seen), 32'h1);
        chk("lim_reuse_dok", 32'(dok_seen), 32'h1);
        r_en = 1'b0; inst_addr = 32'hc; step();
        chk("lim_still_full", 32'(ok_seen), 32'h0);
        inst_req = 1'b0; r_en = 1'b1;
        repeat (4) step();

        // AR backpressure
        r_en = 1'b0; arready = 1'b0; inst_req = 1'b1; inst_addr = 32'h1000; step();
        chk("bp_ok0", 32'(ok_seen), 32'h1);
        inst_addr = 32'h1004;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("bp_stall_ok", 32'(ok_seen), 32'h0);
            chk("bp_arvalid", 32'(arvalid), 32'h1);
            chk("bp_araddr", araddr, 32'h1000);
        end
        arready = 1'b1; step();
        chk("bp_ok1", 32'(ok_seen), 32'h1);
        chk("bp_araddr1", araddr, 32'h1004);
        inst_req = 1'b0; r_en = 1'b1;
        repeat (4) step();

        // stray R beat and write requests
        r_en = 1'b0; stray_en = 1'b1; step();
        chk("stray_rready", 32'(rdy_seen), 32'h0);
        chk("stray_dok", 32'(dok_seen), 32'h0);
        stray_en = 1'b0; inst_req = 1'b1; inst_wr = 1'b1; any_ok = 1'b0;
        repeat (5) begin step(); any_ok |= ok_seen; end
        chk("wr_block", 32'(any_ok), 32'h0);
        inst_wr = 1'b0; inst_req = 1'b0;

        // reset mid-flight
        inst_req = 1'b1; inst_addr = 32'h2000; step();
        inst_addr = 32'h2004; step();
        chk("rst_mid_arvalid", 32'(arvalid), 32'h1);
        inst_req = 1'b0; resetn = 1'b0; step();
        chk("rst_mid_arvalid0", 32'(arvalid), 32'h0);
        chk("rst_mid_rready0", 32'(rready), 32'h0);
        resetn = 1'b1; inst_req = 1'b1; inst_addr = 32'h3000; step();
        chk("rst_mid_accept", 32'(ok_seen), 32'h1);
        inst_req = 1'b0; r_en = 1'b1;
        repeat (4) step();

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            resetn    = ($urandom_range(0, 199) != 0);
            inst_req  = ($urandom_range(0, 3) != 0);
            inst_wr   = ($urandom_range(0, 15) == 0);
            inst_addr = $urandom & 32'hffff_fffc;
            inst_size = 2'($urandom);
            arready   = ($urandom_range(0, 2) != 0);
            r_en      = ($urandom_range(0, 1) != 0);
            stray_en  = ($urandom_range(0, 7) == 0);
            r_resp    = 2'($urandom);
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
